pipe_cla_addsub: RTL and testbench
==================================

// Module: pipe_cla_addsub
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor for the RV32 ALU datapath.
//  Operands are split into STAGES equal segments. Each pipeline stage adds one segment
//  with BLOCK-bit lookahead groups and registers its carry into the next stage.
//  A valid/ready handshake gives full throughput (1 op/cycle) and backpressure.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; WIDTH % STAGES == 0
//  STAGES  2   pipeline depth = latency in cycles; 1..WIDTH/BLOCK
//  BLOCK   4   lookahead group width; (WIDTH/STAGES) % BLOCK == 0
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      operation presented
//  in_ready   out  1      block accepts the operation this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_sub     in   1      1: A - B, computed as A + ~B + 1; 0: A + B + in_cin
//  in_cin     in   1      carry-in; ignored when in_sub=1
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts the result
//  out_sum    out  WIDTH  result
//  out_cout   out  1      carry out of the MSB; for subtract, 1 = no borrow
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): all stage valid bits clear; out_valid, out_sum and
//    out_cout go to 0; in_ready is forced to 0 while rst_n=0. Any in-flight op is
//    discarded and never appears at the output.
//  - Transfer: an input is taken when in_valid&in_ready. An output is taken when
//    out_valid&out_ready. Outputs hold stable while out_valid&!out_ready.
//  - Stage k (0..STAGES-1) holds a valid bit, segment carry, result bits for segments
//    0..k, and delayed operand segments k+1..STAGES-1. It loads when it is empty or its
//    downstream stage is advancing (last stage: out_ready). in_ready = stage-0 load
//    condition. No bubbles: a full pipeline with out_ready=1 accepts and retires 1 op/cycle.
//  - Latency: exactly STAGES cycles from input transfer to out_valid when unstalled.
//  - Arithmetic: b_eff = in_sub ? ~in_b : in_b; c0 = in_sub ? 1 : in_cin.
//    Result = (in_a + b_eff + c0) mod 2^WIDTH; out_cout = bit WIDTH of that sum.
//  - Within a segment: per-bit p=a|b, g=a&b; group carries by lookahead
//    (c[i+1] = g[i] | p[i]&c[i], expanded, no ripple inside a group). Groups chain via
//    group P/G inside the segment.
//  - Ordering: results leave in acceptance order; none are dropped or duplicated.
//  - STAGES=1: single registered stage, in_ready = !out_valid | out_ready.
// CONFIGURATION
//  - Macro PIPE_CLA_FLAGS_EN. When defined, these outputs are added and registered with
//    out_sum (reset 0):
//      out_zero  1  (out_sum == 0)
//      out_neg   1  out_sum[WIDTH-1]
//      out_ovf   1  signed overflow = carry into MSB ^ out_cout
//  - When undefined, these ports do not exist and no flag logic is built.
// STRUCTURE
//  - Package pipe_cla_pkg: localparam SEG_W = WIDTH/STAGES, GROUPS = SEG_W/BLOCK;
//    typedef of the stage register struct (valid, carry, sum, a/b remainder);
//    function cla_group_pg(p,g) returning group P/G.
//  - One sub-module, cla_block: combinational BLOCK-bit lookahead adder with inputs
//    a, b, cin and outputs sum, group P, group G. Instantiated GROUPS times per stage.
//  - Parameter legality is checked at elaboration; illegal combinations are $fatal.
// TESTING  (defaults WIDTH=32 STAGES=2 BLOCK=4, flags enabled)
//  1. rst_n=0 for 3 cycles, in_valid=1 -> in_ready=0, out_valid=0, out_sum=0, no
//     transfer; after release in_ready=1.
//  2. Add: 0xFFFF_FFFF + 0x0000_0001, cin=0 -> 2 cycles later out_sum=0, cout=1,
//     zero=1, ovf=0.
//  3. Sub: 0x8000_0000 - 0x0000_0001 -> out_sum=0x7FFF_FFFF, cout=1, ovf=1, neg=0.
//  4. Cross-stage carry: 0x0000_FFFF + 0x0000_0001, cin=1 -> out_sum=0x0001_0001,
//     cout=0.
//  5. Stream 16 random ops back-to-back, out_ready toggling 1,0,1,0 ->
//     in-order results match the reference model; in_ready drops when both stages are
//     full and stalled.
//  6. Two ops in flight, rst_n=0 for 1 cycle -> neither op ever asserts out_valid;
//     the next op completes normally.

Source files
------------

// File: rtl/pipe_cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//
// Contents:
//   DEF_WIDTH / DEF_STAGES / DEF_BLOCK  default configuration of the adder
//   SEG_W, GROUPS                       segment width and lookahead groups per
//                                       segment for the default configuration
//   MAX_WIDTH, MAX_BLOCK                upper bounds supported by the fixed-size
//                                       stage record and the group P/G helper
//   grp_pg_t                            group propagate/generate pair
//   stage_t                             one pipeline stage register record
//   cla_group_pg()                      folds per-bit p/g into group P/G
package pipe_cla_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 2;
    localparam int DEF_BLOCK  = 4;

    localparam int SEG_W  = DEF_WIDTH / DEF_STAGES;
    localparam int GROUPS = SEG_W / DEF_BLOCK;

    localparam int MAX_WIDTH = 64;
    localparam int MAX_BLOCK = 32;

    typedef struct packed {
        logic p;
        logic g;
    } grp_pg_t;

    // Stage record: the sum field accumulates finished segments, while a/b
    // carry the operands forward so later stages can add their own segment.
    // Fields are sized for MAX_WIDTH; a narrower adder uses the low bits.
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic [MAX_WIDTH-1:0] sum;
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
    } stage_t;

    // Group generate is true when the group produces a carry on its own;
    // group propagate is true when every bit passes an incoming carry through.
    // Only the low n bits of p/g take part.
    function automatic grp_pg_t cla_group_pg(input logic [MAX_BLOCK-1:0] p,
                                             input logic [MAX_BLOCK-1:0] g,
                                             input int                   n);
        grp_pg_t r;
        r.p = 1'b1;
        r.g = 1'b0;
        for (int i = 0; i < MAX_BLOCK; i++) begin
            if (i < n) begin
                r.g = g[i] | (p[i] & r.g);
                r.p = r.p & p[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_cla_addsub_cla_block.sv
// cla_block: combinational BLOCK-bit carry-lookahead adder group.
//
// Ports:
//   a, b    [BLOCK]  operand bits of this group
//   cin     1        carry into the group
//   sum     [BLOCK]  sum bits
//   grp_p   1        group propagate (all bits propagate)
//   grp_g   1        group generate (group produces a carry by itself)
module cla_block
    import pipe_cla_pkg::*;
#(
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             grp_p,
    output logic             grp_g
);

    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] c;
    logic             acc;
    logic             run;
    grp_pg_t          pg;

    assign p = a | b;
    assign g = a & b;

    // Each internal carry is built as a flat sum of products:
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, so no carry ripples
    // through the group. The loops only enumerate the product terms.
    always_comb begin
        acc  = 1'b0;
        run  = 1'b0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLOCK - 1; i++) begin
            acc = g[i];
            run = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (run & g[j]);
                run = run & p[j];
            end
            c[i+1] = acc | (run & cin);
        end
    end

    assign sum = a ^ b ^ c;

    assign pg    = cla_group_pg(MAX_BLOCK'(p), MAX_BLOCK'(g), BLOCK);
    assign grp_p = pg.p;
    assign grp_g = pg.g;

endmodule

// File: rtl/pipe_cla_addsub.sv
// pipe_cla_addsub: pipelined carry-lookahead adder/subtractor with a
// valid/ready handshake on both sides (1 op/cycle, STAGES cycles latency).
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   in_valid / in_ready   input handshake
//   in_a, in_b  [WIDTH]   operands
//   in_sub                1: A - B (A + ~B + 1), 0: A + B + in_cin
//   in_cin                carry-in for add, ignored for subtract
//   out_valid / out_ready output handshake
//   out_sum     [WIDTH]   result
//   out_cout              carry out of the MSB (subtract: 1 = no borrow)
//
// Optional build macro PIPE_CLA_FLAGS_EN adds registered result flags:
//   out_zero (sum == 0), out_neg (sum MSB), out_ovf (signed overflow).
//
// Stage k adds operand segment k using BLOCK-bit lookahead groups and
// registers its segment carry for stage k+1.
module pipe_cla_addsub
    import pipe_cla_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int BLOCK  = DEF_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef PIPE_CLA_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf
`endif
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int NGRP = SEG / BLOCK;
    localparam int LAST = STAGES - 1;

    if (STAGES < 1 || BLOCK < 1 || WIDTH < 1 || WIDTH > MAX_WIDTH ||
        BLOCK > MAX_BLOCK || (WIDTH % STAGES) != 0 || SEG < BLOCK ||
        (SEG % BLOCK) != 0) begin : g_bad_params
        $fatal(1, "pipe_cla_addsub: illegal WIDTH/STAGES/BLOCK combination");
    end

    stage_t           st_q    [STAGES];
    logic [WIDTH-1:0] stg_a   [STAGES];
    logic [WIDTH-1:0] stg_b   [STAGES];
    logic [WIDTH-1:0] stg_sum [STAGES];
    logic             stg_v   [STAGES];
    logic             stg_c   [STAGES];
    logic [STAGES:0]  load;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Subtraction is A + ~B + 1, so the inversion and forced carry happen
    // once at the input and every stage is a plain adder.
    assign b_eff = in_sub ? ~in_b : in_b;
    assign c0    = in_sub | in_cin;

    // A stage may load when it is empty or its contents move on this cycle;
    // the chain runs back from the consumer so a full pipe still streams.
    assign load[STAGES] = out_ready;
    assign in_ready     = rst_n & load[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] sum_src;
        logic [WIDTH-1:0] sum_nxt;
        logic             c_src;
        logic             v_src;
        logic [NGRP:0]    gc;
        logic [NGRP-1:0]  gp;
        logic [NGRP-1:0]  gg;
        logic [SEG-1:0]   seg_sum;

        if (k == 0) begin : g_first
            assign a_src   = in_a;
            assign b_src   = b_eff;
            assign c_src   = c0;
            assign v_src   = in_valid;
            assign sum_src = '0;
        end else begin : g_next
            assign a_src   = st_q[k-1].a[WIDTH-1:0];
            assign b_src   = st_q[k-1].b[WIDTH-1:0];
            assign c_src   = st_q[k-1].carry;
            assign v_src   = st_q[k-1].valid;
            assign sum_src = st_q[k-1].sum[WIDTH-1:0];
        end

        // Groups inside the segment are linked through their group P/G.
        assign gc[0] = c_src;
        for (genvar j = 0; j < NGRP; j++) begin : g_grp
            cla_block #(.BLOCK(BLOCK)) u_cla (
                .a     (a_src[k*SEG + j*BLOCK +: BLOCK]),
                .b     (b_src[k*SEG + j*BLOCK +: BLOCK]),
                .cin   (gc[j]),
                .sum   (seg_sum[j*BLOCK +: BLOCK]),
                .grp_p (gp[j]),
                .grp_g (gg[j])
            );
            assign gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end

        // Merge this segment into the partial result from earlier stages.
        always_comb begin
            sum_nxt                = sum_src;
            sum_nxt[k*SEG +: SEG]  = seg_sum;
        end

        assign load[k]    = !st_q[k].valid || load[k+1];
        assign stg_a[k]   = a_src;
        assign stg_b[k]   = b_src;
        assign stg_sum[k] = sum_nxt;
        assign stg_v[k]   = v_src;
        assign stg_c[k]   = gc[NGRP];
    end

    // Stage registers. Data only moves with a valid op so a stalled or
    // empty stage keeps its last contents; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    st_q[k].valid <= stg_v[k];
                    if (stg_v[k]) begin
                        st_q[k].carry <= stg_c[k];
                        st_q[k].sum   <= MAX_WIDTH'(stg_sum[k]);
                        st_q[k].a     <= MAX_WIDTH'(stg_a[k]);
                        st_q[k].b     <= MAX_WIDTH'(stg_b[k]);
                    end
                end
            end
        end
    end

    assign out_valid = st_q[LAST].valid;
    assign out_sum   = st_q[LAST].sum[WIDTH-1:0];
    assign out_cout  = st_q[LAST].carry;

`ifdef PIPE_CLA_FLAGS_EN
    logic zero_q;
    logic neg_q;
    logic ovf_q;
    logic msb_cin;

    // The carry into the MSB is recovered from the MSB's own sum bit.
    assign msb_cin = stg_a[LAST][WIDTH-1] ^ stg_b[LAST][WIDTH-1] ^ stg_sum[LAST][WIDTH-1];

    // Flags are captured alongside the final sum so they share its timing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (load[LAST] && stg_v[LAST]) begin
            zero_q <= (stg_sum[LAST] == '0);
            neg_q  <= stg_sum[LAST][WIDTH-1];
            ovf_q  <= msb_cin ^ stg_c[LAST];
        end
    end

    assign out_zero = zero_q;
    assign out_neg  = neg_q;
    assign out_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Testbench for pipe_cla_addsub (WIDTH=32, STAGES=2, BLOCK=4). Flag
// checks are included when PIPE_CLA_FLAGS_EN is defined.
module tb_pipe_cla_addsub;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int BLOCK  = 4;
    localparam longint SMAX = (longint'(1) <<< (WIDTH - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (WIDTH - 1));

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef PIPE_CLA_FLAGS_EN
    logic             out_zero;
    logic             out_neg;
    logic             out_ovf;
`endif

    always #5 clk = ~clk;

    pipe_cla_addsub #(.WIDTH(WIDTH), .STAGES(STAGES), .BLOCK(BLOCK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
`ifdef PIPE_CLA_FLAGS_EN
        ,
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_ovf   (out_ovf)
`endif
    );

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             zero;
        logic             neg;
        logic             ovf;
    } result_t;

    result_t          expQ[$];
    result_t          lastRes;
    int               passCount = 0;
    int               checkCount = 0;
    bit               acceptedNow;
    bit               retiredNow;
    bit               seenStall;
    bit               holdPending = 0;
    logic [WIDTH-1:0] heldSum;
    logic             heldCout;

    // Reference arithmetic: plain wide and signed integer math on the operands.
    function automatic result_t refModel(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                         logic sub, logic cin);
        result_t        r;
        logic [WIDTH:0] wide;
        longint         sa;
        longint         sb;
        longint         sres;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            r.sum  = a - b;
            r.cout = (a >= b);
            sres   = sa - sb;
        end else begin
            wide   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            r.sum  = wide[WIDTH-1:0];
            r.cout = wide[WIDTH];
            sres   = sa + sb + longint'(cin);
        end
        r.zero = (r.sum == '0);
        r.neg  = r.sum[WIDTH-1];
        r.ovf  = (sres > SMAX) || (sres < SMIN);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sub, input logic cin,
                                 input logic valid, input logic ready);
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_cin    = cin;
        in_valid  = valid;
        out_ready = ready;
    endtask

    // One clock: observe both handshakes at the falling edge, then step past
    // the rising edge so the caller can drive the next inputs.
    task automatic stepCycle();
        result_t e;
        @(negedge clk);
        acceptedNow = 0;
        retiredNow  = 0;
        if (!rst_n) begin
            checkOutput("reset_in_ready", in_ready, 0);
            expQ.delete();
            holdPending = 0;
        end else begin
            if (holdPending) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_sum", out_sum, heldSum);
                checkOutput("hold_cout", out_cout, heldCout);
            end
            holdPending = out_valid && !out_ready;
            heldSum     = out_sum;
            heldCout    = out_cout;
            if (in_valid && !in_ready) seenStall = 1;
            if (out_valid && out_ready) begin
                retiredNow   = 1;
                lastRes.sum  = out_sum;
                lastRes.cout = out_cout;
`ifdef PIPE_CLA_FLAGS_EN
                lastRes.zero = out_zero;
                lastRes.neg  = out_neg;
                lastRes.ovf  = out_ovf;
`endif
                if (expQ.size() == 0) begin
                    checkOutput("output_without_op", out_valid, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("stream_sum", out_sum, e.sum);
                    checkOutput("stream_cout", out_cout, e.cout);
`ifdef PIPE_CLA_FLAGS_EN
                    checkOutput("stream_zero", out_zero, e.zero);
                    checkOutput("stream_neg", out_neg, e.neg);
                    checkOutput("stream_ovf", out_ovf, e.ovf);
`endif
                end
            end
            if (in_valid && in_ready) begin
                acceptedNow = 1;
                expQ.push_back(refModel(in_a, in_b, in_sub, in_cin));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Issue one op into an empty pipe and wait for it with a bounded count.
    task automatic directedOp(input string tag, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b, input logic sub, input logic cin,
                              input logic [WIDTH-1:0] expSum, input logic expCout);
        int lat;
        applyStimulus(a, b, sub, cin, 1'b1, 1'b1);
        stepCycle();
        checkOutput({tag, "_accepted"}, acceptedNow, 1);
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            stepCycle();
            if (retiredNow) begin
                lat = i;
                break;
            end
        end
        checkOutput({tag, "_latency"}, lat, STAGES);
        checkOutput({tag, "_sum"}, lastRes.sum, expSum);
        checkOutput({tag, "_cout"}, lastRes.cout, expCout);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sent;
        result_t r;
        logic rdy;

        // Reset held for three cycles with a request pending.
        rst_n = 1'b0;
        applyStimulus($urandom, $urandom, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("reset_out_valid", out_valid, 0);
            checkOutput("reset_out_sum", out_sum, 0);
            checkOutput("reset_out_cout", out_cout, 0);
        end
        rst_n = 1'b1;
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("release_in_ready", in_ready, 1);
        checkOutput("release_out_valid", out_valid, 0);

        $display("[TB] directed add/sub cases");
        directedOp("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b1);
`ifdef PIPE_CLA_FLAGS_EN
        checkOutput("add_wrap_zero", lastRes.zero, 1);
        checkOutput("add_wrap_ovf", lastRes.ovf, 0);
`endif
        directedOp("sub_min", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1);
`ifdef PIPE_CLA_FLAGS_EN
        checkOutput("sub_min_ovf", lastRes.ovf, 1);
        checkOutput("sub_min_neg", lastRes.neg, 0);
`endif
        directedOp("cross_stage", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0001_0001, 1'b0);
        directedOp("sub_borrow", 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);

        $display("[TB] random stream with toggling out_ready");
        seenStall = 0;
        sent      = 0;
        rdy       = 1'b1;
        applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, rdy);
        for (int cyc = 0; cyc < 200 && sent < 16; cyc++) begin
            stepCycle();
            rdy = !rdy;
            if (acceptedNow) begin
                sent++;
                if (sent < 16)
                    applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)),
                                  1'($urandom_range(0, 1)), 1'b1, rdy);
                else
                    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, rdy);
            end else begin
                out_ready = rdy;
            end
        end
        checkOutput("stream_sent", sent, 16);
        checkOutput("stream_stall_seen", seenStall, 1);
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20 && expQ.size() > 0; i++) stepCycle();
        checkOutput("stream_drained", expQ.size(), 0);
        checkOutput("stream_idle_valid", out_valid, 0);

        $display("[TB] reset with two ops in flight");
        applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("flush_op1_accepted", acceptedNow, 1);
        applyStimulus(32'h0F0F_0F0F, 32'h0000_0F0F, 1'b1, 1'b0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("flush_op2_accepted", acceptedNow, 1);
        rst_n = 1'b0;
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("flush_out_valid", out_valid, 0);
        rst_n = 1'b1;
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            checkOutput("flush_no_output", out_valid, 0);
        end
        r = refModel(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b1);
        directedOp("after_flush", 32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b1, r.sum, r.cout);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
